moving_average: RTL and testbench

//  Boxcar (moving-average) smoothing stage ahead of value_switch in a control cell.

---
 rtl/moving_average.sv | 84 ++++++++
 tb/tb_moving_average.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/moving_average.sv
// Boxcar smoothing stage: averages the last 2^shift signed samples, one output per input sample.
// Window shift is runtime-loadable over param_in/param_en; a load flushes all history.
module moving_average #(
  parameter int MSB           = 31,
  parameter int LOG2_DEPTH    = 3,
  parameter int DEFAULT_SHIFT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [MSB:0] data_in,
  input  logic         data_en,
  input  logic [MSB:0] param_in,
  input  logic         param_en,
  output logic [MSB:0] data_out,
  output logic         data_en_out
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = $clog2(LOG2_DEPTH + 1);
  localparam int SUMW  = MSB + 1 + LOG2_DEPTH;

  logic [MSB:0]            hist [DEPTH];
  logic [LOG2_DEPTH-1:0]   wr_ptr;
  logic [LOG2_DEPTH-1:0]   rd_ptr;
  logic [LOG2_DEPTH:0]     cnt;
  logic [LOG2_DEPTH:0]     win;
  logic [SW-1:0]           shift;
  logic [MSB:0]            oldest;
  logic signed [SUMW-1:0]  sum;
  logic signed [SUMW-1:0]  sum_next;
  logic signed [SUMW-1:0]  avg;
  logic                    sample;

  assign sample = data_en && !param_en;

  // Until the window has filled, the sample leaving the window is an implicit zero.
  always_comb begin
    win      = (LOG2_DEPTH + 1)'(1) << shift;
    rd_ptr   = wr_ptr - win[LOG2_DEPTH-1:0];
    oldest   = (cnt >= win) ? hist[rd_ptr] : '0;
    sum_next = sum + {{LOG2_DEPTH{data_in[MSB]}}, data_in}
                   - {{LOG2_DEPTH{oldest[MSB]}}, oldest};
    avg      = sum_next >>> shift;
  end

  always_ff @(posedge clk) begin
    if (sample) begin
      hist[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift       <= SW'(DEFAULT_SHIFT);
      sum         <= '0;
      cnt         <= '0;
      wr_ptr      <= '0;
      data_out    <= '0;
      data_en_out <= 1'b0;
    end else begin
      data_en_out <= 1'b0;
      if (param_en) begin
        if (param_in > (MSB + 1)'(LOG2_DEPTH)) begin
          shift <= SW'(LOG2_DEPTH);
        end else begin
          shift <= param_in[SW-1:0];
        end
        sum    <= '0;
        cnt    <= '0;
        wr_ptr <= '0;
      end else if (data_en) begin
        sum    <= sum_next;
        wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
        if (cnt != (LOG2_DEPTH + 1)'(DEPTH)) begin
          cnt <= cnt + (LOG2_DEPTH + 1)'(1);
        end
        // The averaged value always fits in MSB+1 bits, so plain truncation is exact.
        data_out    <= avg[MSB:0];
        data_en_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_moving_average.sv
// Self-checking bench for moving_average: directed vector table, multi-cycle corner
// sequences and randomized traffic compared against a queue-based window model.
module tb_moving_average;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        data_en;
  logic [31:0] param_in;
  logic        param_en;
  logic [31:0] data_out;
  logic        data_en_out;

  int checks = 0;
  int errors = 0;

  moving_average #(.MSB(31), .LOG2_DEPTH(3), .DEFAULT_SHIFT(2)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_en(data_en),
    .param_in(param_in),
    .param_en(param_en),
    .data_out(data_out),
    .data_en_out(data_en_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          pe;
    logic [31:0] pin;
    bit          de;
    logic [31:0] din;
    bit          exp_en;
    logic [31:0] exp_out;
  } vec_t;

  // Reference model: the window is simply the last 2^shift samples since the last flush.
  int          m_shift;
  longint      m_hist[$];
  bit          m_en;
  logic [31:0] m_out;

  function automatic void model_reset();
    m_shift = 2;
    m_hist.delete();
    m_en  = 1'b0;
    m_out = '0;
  endfunction

  function automatic void model_step(bit pe, logic [31:0] pin, bit de, logic [31:0] din);
    longint s;
    longint q;
    int     w;
    m_en = 1'b0;
    if (pe) begin
      m_shift = (pin > 32'd3) ? 3 : int'(pin);
      m_hist.delete();
    end else if (de) begin
      m_hist.push_back(longint'($signed(din)));
      if (m_hist.size() > 8) void'(m_hist.pop_front());
      w = 1 << m_shift;
      s = 0;
      for (int k = 0; k < w; k++) begin
        if (k < m_hist.size()) s += m_hist[m_hist.size() - 1 - k];
      end
      q = s / w;
      if ((s % w != 0) && (s < 0)) q = q - 1;
      m_out = q[31:0];
      m_en  = 1'b1;
    end
  endfunction

  task automatic checkOutput(string name, bit exp_en, logic [31:0] exp_out);
    checks++;
    if (data_en_out !== exp_en || (exp_en && data_out !== exp_out) ||
        (!exp_en && data_out !== exp_out)) begin
      errors++;
      $display("[TB] FAIL %s: got en=%0b out=%0d (0x%08h), expected en=%0b out=%0d (0x%08h)",
               name, data_en_out, $signed(data_out), data_out, exp_en, $signed(exp_out), exp_out);
    end
  endtask

  // Drives one cycle of inputs, then samples outputs 1 time unit after the edge.
  task automatic applyStimulus(bit pe, logic [31:0] pin, bit de, logic [31:0] din);
    param_en = pe;
    param_in = pin;
    data_en  = de;
    data_in  = din;
    @(posedge clk);
    #1;
    model_step(pe, pin, de, din);
    param_en = 1'b0;
    data_en  = 1'b0;
  endtask

  task automatic sample_model(string name, logic [31:0] din);
    applyStimulus(1'b0, '0, 1'b1, din);
    checkOutput(name, m_en, m_out);
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(string n, bit pe, logic [31:0] pin, bit de, logic [31:0] din,
                              bit ee, logic [31:0] eo);
    vec_t v;
    v.name = n; v.pe = pe; v.pin = pin; v.de = de; v.din = din;
    v.exp_en = ee; v.exp_out = eo;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk("step1",       0, 0, 1, 8,          1, 2));
    vecs.push_back(mk("step2",       0, 0, 1, 8,          1, 4));
    vecs.push_back(mk("step3",       0, 0, 1, 8,          1, 6));
    vecs.push_back(mk("step4",       0, 0, 1, 8,          1, 8));
    vecs.push_back(mk("step5",       0, 0, 1, 8,          1, 8));
    vecs.push_back(mk("idle_hold",   0, 0, 0, 0,          0, 8));
    vecs.push_back(mk("param1",      1, 1, 0, 0,          0, 8));
    vecs.push_back(mk("neg1",        0, 0, 1, -32'sd1,    1, -32'sd1));
    vecs.push_back(mk("neg2",        0, 0, 1, -32'sd2,    1, -32'sd2));
    vecs.push_back(mk("neg3",        0, 0, 1, -32'sd3,    1, -32'sd3));
    vecs.push_back(mk("collision",   1, 0, 1, 100,        0, -32'sd3));
    vecs.push_back(mk("after_flush", 0, 0, 1, 5,          1, 5));
    vecs.push_back(mk("idle_hold2",  0, 0, 0, 0,          0, 5));

    rst = 1'b1; data_in = '0; data_en = 1'b0; param_in = '0; param_en = 1'b0;
    model_reset();
    #2;
    checkOutput("reset_state", 1'b0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].pe, vecs[i].pin, vecs[i].de, vecs[i].din);
      checkOutput(vecs[i].name, vecs[i].exp_en, vecs[i].exp_out);
    end

    // Mid-cycle asynchronous reset discards history and restores the default window.
    sample_model("pre_reset", 32'd7);
    #3 rst = 1'b1;
    #1 checkOutput("async_reset", 1'b0, 32'd0);
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, 1'b1, 32'd8);
    checkOutput("post_reset_first", 1'b1, 32'd2);

    // Out-of-range shift clamps to window 8; 20 samples wrap the history buffer.
    applyStimulus(1'b1, 32'd9, 1'b0, '0);
    checkOutput("clamp_load", 1'b0, 32'd2);
    for (int i = 1; i <= 20; i++) begin
      sample_model($sformatf("wrap_s%0d", i), 32'(i));
      if (i == 8)  checkOutput("wrap_at8", 1'b1, 32'd4);
      if (i == 20) checkOutput("wrap_at20", 1'b1, 32'd16);
    end

    // Full-scale samples must not overflow the accumulator.
    applyStimulus(1'b1, 32'd3, 1'b0, '0);
    for (int i = 0; i < 8; i++) sample_model($sformatf("min_s%0d", i), 32'h8000_0000);
    checkOutput("min_full", 1'b1, 32'h8000_0000);
    for (int i = 0; i < 8; i++) sample_model($sformatf("max_s%0d", i), 32'h7FFF_FFFF);
    checkOutput("max_full", 1'b1, 32'h7FFF_FFFF);

    for (int i = 0; i < 600; i++) begin
      bit          pe;
      bit          de;
      logic [31:0] pin;
      logic [31:0] din;
      pe  = ($urandom_range(0, 24) == 0);
      de  = ($urandom_range(0, 3) != 0);
      pin = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 4));
      din = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 200)) - 100);
      applyStimulus(pe, pin, de, din);
      checkOutput($sformatf("rand_%0d", i), m_en, m_out);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
